// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: pulls opcode/extension/immediate bytes over a
// byte-wide memory handshake, steers the external decoder, and hands one
// assembled instruction at a time to the execute stage.
module instr_fetch_seq #(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        dec_opcode,
  output logic [7:0]        dec_opext,
  input  logic              dec_need_opext,
  input  logic              dec_need_imm,
  input  logic              dec_imm_size,
  input  logic              dec_error,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [7:0]        insn_opcode,
  output logic [7:0]        insn_opext,
  output logic [15:0]       insn_imm,
  output logic [2:0]        insn_len,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  typedef enum logic [2:0] {
    IDLE, FETCH_OP, FETCH_EXT, DECODE, FETCH_IMM_LO, FETCH_IMM_HI, ISSUE, FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] insn_pc_q, insn_pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        opext_q, opext_d;
  logic [15:0]       imm_q, imm_d;
  logic [2:0]        len_q, len_d;
  logic              ext_done_q, ext_done_d;
  // One dead cycle after a flush so the abandoned request visibly drops.
  logic              gap_q, gap_d;
  logic              fetching, take, enter_op, do_flush;

  assign fetching = (state_q == FETCH_OP) || (state_q == FETCH_EXT) ||
                    (state_q == FETCH_IMM_LO) || (state_q == FETCH_IMM_HI);
  assign mem_req  = fetching && !gap_q;
  assign take     = mem_req && mem_ack;
  assign do_flush = flush && (state_q != IDLE);

  assign mem_addr    = pc_q;
  assign dec_opcode  = opcode_q;
  assign dec_opext   = opext_q;
  assign insn_valid  = (state_q == ISSUE);
  assign insn_opcode = opcode_q;
  assign insn_opext  = opext_q;
  assign insn_imm    = imm_q;
  assign insn_len    = len_q;
  assign insn_pc     = insn_pc_q;
  assign fault       = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;

  // Next-state, byte capture and flush redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_pc_d  = insn_pc_q;
    fault_pc_d = fault_pc_q;
    opcode_d   = opcode_q;
    opext_d    = opext_q;
    imm_d      = imm_q;
    len_d      = len_q;
    ext_done_d = ext_done_q;
    gap_d      = 1'b0;
    enter_op   = 1'b0;

    case (state_q)
      IDLE: begin
        state_d  = FETCH_OP;
        enter_op = 1'b1;
      end
      FETCH_OP: if (take) begin
        opcode_d = mem_data;
        state_d  = DECODE;
      end
      FETCH_EXT: if (take) begin
        opext_d    = mem_data;
        ext_done_d = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // Error from the first decode pass is meaningless when the opext
        // byte has not been fetched yet.
        if (!ext_done_q && dec_need_opext) state_d = FETCH_EXT;
        else if (dec_error) begin
          state_d    = FAULT;
          fault_pc_d = insn_pc_q;
        end
        else if (dec_need_imm) state_d = FETCH_IMM_LO;
        else                   state_d = ISSUE;
      end
      FETCH_IMM_LO: if (take) begin
        imm_d[7:0] = mem_data;
        state_d    = dec_imm_size ? FETCH_IMM_HI : ISSUE;
      end
      FETCH_IMM_HI: if (take) begin
        imm_d[15:8] = mem_data;
        state_d     = ISSUE;
      end
      ISSUE: if (insn_ready) begin
        state_d  = FETCH_OP;
        enter_op = 1'b1;
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase

    if (take) begin
      pc_d  = pc_q + 1'b1;
      len_d = len_q + 3'd1;
    end

    // Flush wins over everything, including a byte acked this cycle.
    if (do_flush) begin
      state_d  = FETCH_OP;
      pc_d     = flush_pc;
      gap_d    = 1'b1;
      enter_op = 1'b1;
    end

    if (enter_op) begin
      opcode_d   = '0;
      opext_d    = '0;
      imm_d      = '0;
      len_d      = '0;
      ext_done_d = 1'b0;
      insn_pc_d  = pc_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      insn_pc_q  <= '0;
      fault_pc_q <= '0;
      opcode_q   <= '0;
      opext_q    <= '0;
      imm_q      <= '0;
      len_q      <= '0;
      ext_done_q <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      insn_pc_q  <= insn_pc_d;
      fault_pc_q <= fault_pc_d;
      opcode_q   <= opcode_d;
      opext_q    <= opext_d;
      imm_q      <= imm_d;
      len_q      <= len_d;
      ext_done_q <= ext_done_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a small memory model and a
// table-driven stand-in for the instruction decoder.
module tb_instr_fetch_seq;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    dec_opcode, dec_opext;
  logic          dec_need_opext, dec_need_imm, dec_imm_size, dec_error;
  logic          insn_valid, insn_ready;
  logic [7:0]    insn_opcode, insn_opext;
  logic [15:0]   insn_imm;
  logic [2:0]    insn_len;
  logic [AW-1:0] insn_pc;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          fault;
  logic [AW-1:0] fault_pc;

  int total = 0;
  int bad   = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  logic [7:0] mem [0:255];

  instr_fetch_seq #(.ADDR_W(AW), .RESET_PC(24'h000000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .dec_opcode(dec_opcode), .dec_opext(dec_opext),
    .dec_need_opext(dec_need_opext), .dec_need_imm(dec_need_imm),
    .dec_imm_size(dec_imm_size), .dec_error(dec_error),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_opcode(insn_opcode), .insn_opext(insn_opext), .insn_imm(insn_imm),
    .insn_len(insn_len), .insn_pc(insn_pc),
    .flush(flush), .flush_pc(flush_pc), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // Memory: low address byte indexes a 256-byte array; ack after ack_wait idle cycles.
  assign mem_ack  = mem_req && (wait_cnt >= ack_wait);
  assign mem_data = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Decoder stand-in covering the opcodes used below.
  always_comb begin
    dec_need_opext = 1'b0;
    dec_need_imm   = 1'b0;
    dec_imm_size   = 1'b0;
    dec_error      = 1'b0;
    case (dec_opcode)
      8'hB0: dec_need_imm = 1'b1;
      8'hB8: begin dec_need_imm = 1'b1; dec_imm_size = 1'b1; end
      8'h7C: dec_error = 1'b1;
      8'hCE, 8'hCF: begin
        dec_need_opext = 1'b1;
        case (dec_opext)
          8'hD0: begin dec_need_imm = 1'b1; dec_imm_size = 1'b1; end
          8'h70: dec_need_imm = 1'b1;
          8'h64: dec_error = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!insn_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic accept();
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
  endtask

  task automatic do_flush(input logic [AW-1:0] pc);
    flush_pc = pc;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hB8; mem[8'h11] = 8'h34; mem[8'h12] = 8'h12;
    mem[8'h13] = 8'hCE; mem[8'h14] = 8'hD0; mem[8'h15] = 8'hAA; mem[8'h16] = 8'hBB;
    mem[8'h17] = 8'hCF; mem[8'h18] = 8'h70; mem[8'h19] = 8'h11;
    mem[8'h1A] = 8'hCE; mem[8'h1B] = 8'h02;
    mem[8'h20] = 8'h7C;
    mem[8'h30] = 8'hCE; mem[8'h31] = 8'h64;
    mem[8'hFF] = 8'hB0;

    reset = 1'b1; flush = 1'b0; flush_pc = '0; insn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", insn_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_pc", fault_pc, 0);
    chk("rst_len", insn_len, 0);
    chk("rst_imm", insn_imm, 0);
    chk("rst_dec_opcode", dec_opcode, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    chk("idle_req", mem_req, 0);
    tick();
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    wait_valid("lat_len1", 2);
    chk("l1_opcode", insn_opcode, 8'h00);
    chk("l1_len", insn_len, 1);
    chk("l1_imm", insn_imm, 0);
    chk("l1_pc", insn_pc, 0);
    chk("l1_issue_req", mem_req, 0);
    accept();
    chk("l1_valid_drop", insn_valid, 0);
    chk("l1_next_addr", mem_addr, 1);

    // Flush while an opcode byte is being acked: byte discarded, redirect.
    do_flush(24'h000010);
    chk("fl_req_drop", mem_req, 0);
    chk("fl_addr", mem_addr, 24'h10);
    tick();
    chk("fl_req_up", mem_req, 1);
    wait_valid("lat_len3", 4);
    chk("b8_opcode", insn_opcode, 8'hB8);
    chk("b8_imm", insn_imm, 16'h1234);
    chk("b8_len", insn_len, 3);
    chk("b8_pc", insn_pc, 24'h10);
    accept();
    chk("b8_next_addr", mem_addr, 24'h13);

    wait_valid("lat_ce16", 6);
    chk("ced0_opext", insn_opext, 8'hD0);
    chk("ced0_imm", insn_imm, 16'hBBAA);
    chk("ced0_len", insn_len, 4);
    chk("ced0_pc", insn_pc, 24'h13);
    accept();
    wait_valid("lat_ce8", 5);
    chk("cf70_opcode", insn_opcode, 8'hCF);
    chk("cf70_imm", insn_imm, 16'h0011);
    chk("cf70_len", insn_len, 3);
    accept();
    wait_valid("lat_ce0", 4);
    chk("ce02_opext", insn_opext, 8'h02);
    chk("ce02_len", insn_len, 2);
    chk("ce02_imm", insn_imm, 0);
    // Stall in ISSUE: payload holds, no prefetch.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", insn_valid, 1);
      chk("stall_req", mem_req, 0);
      chk("stall_opext", insn_opext, 8'h02);
      chk("stall_pc", insn_pc, 24'h1A);
    end
    accept();
    chk("ce02_next_addr", mem_addr, 24'h1C);

    // Illegal opcode.
    do_flush(24'h000020);
    tick();
    tick();
    tick();
    chk("f7c_fault", fault, 1);
    chk("f7c_fault_pc", fault_pc, 24'h20);
    chk("f7c_req", mem_req, 0);
    chk("f7c_valid", insn_valid, 0);
    repeat (3) tick();
    chk("f7c_hold", fault, 1);
    do_flush(24'h000030);
    chk("f7c_clear", fault, 0);
    tick();
    n = 0; seen = 1'b0;
    while (!fault && n < 40) begin
      tick();
      n++;
      if (insn_valid) seen = 1'b1;
    end
    chk("f64_lat", n, 4);
    chk("f64_fault_pc", fault_pc, 24'h30);
    chk("f64_opext", dec_opext, 8'h64);
    chk("f64_no_valid", seen, 0);
    do_flush(24'h000000);
    chk("f64_clear", fault, 0);
    chk("f64_addr", mem_addr, 0);
    tick();
    chk("resume_req", mem_req, 1);
    wait_valid("resume_lat", 2);
    accept();

    // Wait states, then flush during the high immediate byte.
    ack_wait = 3;
    do_flush(24'h000010);
    tick();
    chk("w3_addr", mem_addr, 24'h10);
    n = 0;
    while (!(mem_req && mem_addr == 24'h12) && n < 40) begin
      tick();
      n++;
    end
    chk("w3_lat_to_hi", n, 9);
    tick();
    do_flush(24'h000040);
    chk("hi_fl_req", mem_req, 0);
    chk("hi_fl_valid", insn_valid, 0);
    chk("hi_fl_addr", mem_addr, 24'h40);
    ack_wait = 1;
    tick();
    chk("hi_fl_req_up", mem_req, 1);
    wait_valid("lat_wait1", 3);
    chk("w1_pc", insn_pc, 24'h40);
    chk("w1_len", insn_len, 1);
    accept();

    // Address wrap.
    ack_wait = 0;
    mem[8'h00] = 8'h5A;
    do_flush(24'hFFFFFF);
    chk("wrap_addr", mem_addr, 24'hFFFFFF);
    tick();
    wait_valid("wrap_lat", 3);
    chk("wrap_opcode", insn_opcode, 8'hB0);
    chk("wrap_imm", insn_imm, 16'h005A);
    chk("wrap_len", insn_len, 2);
    chk("wrap_pc", insn_pc, 24'hFFFFFF);
    accept();
    chk("wrap_next", mem_addr, 24'h000001);

    // Flush coinciding with an accepted instruction.
    wait_valid("a1_lat", 2);
    chk("a1_pc", insn_pc, 24'h1);
    insn_ready = 1'b1;
    do_flush(24'h000050);
    insn_ready = 1'b0;
    chk("hs_fl_valid", insn_valid, 0);
    chk("hs_fl_addr", mem_addr, 24'h50);
    chk("hs_fl_req", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer for the S1C88 core. It reads opcode bytes over a byte-wide memory handshake and drives the combinational instruction decoder. Using the decoder's need_opext/need_imm/imm_size/error results, it fetches the extension byte and immediate bytes, then presents one assembled instruction to the execute stage through a valid/ready handshake. It sits between the bus interface and the execute FSM, and is the decoder's only driver.

## Interface
- ADDR_W, 24, fetch address width
- RESET_PC, 24'h000000, first fetch address after reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  read address, stable while mem_req high
- mem_ack  in  1  mem_data valid this cycle; transaction complete
- mem_data  in  8  read byte
- dec_opcode / dec_opext  out  8 / 8  to decoder, driven from internal opcode/opext registers
- dec_need_opext, dec_need_imm, dec_imm_size, dec_error  in  1 each  decoder results
- insn_valid  out  1  instruction available
- insn_ready  in  1  execute accepts
- insn_opcode / insn_opext  out  8 / 8  opext is 0 when not fetched
- insn_imm  out  16  little-endian; upper byte 0 for 8-bit imm; 0 if none
- insn_len  out  3  total bytes, 1..4
- insn_pc  out  ADDR_W  address of opcode byte
- flush  in  1  abort and redirect
- flush_pc  in  ADDR_W  new fetch address
- fault  out  1  illegal instruction, level
- fault_pc  out  ADDR_W  opcode address of the illegal instruction

## Operation
- States: IDLE, FETCH_OP, FETCH_EXT, DECODE, FETCH_IMM_LO, FETCH_IMM_HI, ISSUE, FAULT.
- Reset values: state IDLE, pc=RESET_PC, mem_req 0, insn_valid 0, fault 0, all payload/fault_pc/dec_* outputs 0.
- IDLE -> FETCH_OP unconditionally.
- mem_req = 1 in the FETCH_* states. mem_addr = pc. Every ack latches the byte, increments pc modulo 2^ADDR_W, and increments the length counter.
- FETCH_OP on entry: clear opcode/opext/imm/len, set ext_done=0, capture insn_pc=pc. On ack: latch opcode -> DECODE.
- FETCH_EXT on ack: latch opext, set ext_done=1 -> DECODE.
- DECODE, one cycle, priority order:
  - if !ext_done && dec_need_opext -> FETCH_EXT. dec_error is ignored here because opext is stale.
  - else if dec_error -> FAULT.
  - else if dec_need_imm -> FETCH_IMM_LO.
  - else -> ISSUE.
- FETCH_IMM_LO on ack: imm[7:0]=byte; -> FETCH_IMM_HI if dec_imm_size else ISSUE.
- FETCH_IMM_HI on ack: imm[15:8]=byte -> ISSUE.
- ISSUE: insn_valid=1, payload stable. On insn_ready -> FETCH_OP.
- FAULT: fault=1, fault_pc=insn_pc, mem_req 0, insn_valid 0. Held until flush.
- flush has top priority in every state except IDLE:
  - next state FETCH_OP at flush_pc; fault cleared next cycle.
  - A byte acked in the same cycle is discarded.
  - A pending request is abandoned (mem_req drops next cycle; the bus is abortable).
  - flush with insn_valid && insn_ready in the same cycle: the handshake completes, then fetch resumes at flush_pc.

## Timing
- mem_data is sampled only in the ack cycle. mem_addr changes only in the cycle after an ack or flush.
- With zero-wait ack, cycles from FETCH_OP entry to insn_valid:
  - len1: 2
  - plain len2: 3
  - plain len3: 4
  - CE/CF with no imm: 4
  - CE/CF with 8-bit imm: 5
  - CE/CF with 16-bit imm: 6
- Each memory wait cycle adds one cycle.
- Accept cycle (valid&&ready) -> FETCH_OP next cycle. No prefetch: mem_req is 0 during ISSUE.
- Decoder outputs are used only in DECODE, one full cycle after the latch.

## Test plan
- Reset, RESET_PC=0, memory[0]=0x00, ack always: first mem_req in 2nd cycle after release, addr 0 -> insn opcode 00, len 1, imm 0, pc 0; next mem_addr 1.
- Bytes B8 34 12 at 0x10 (after flush_pc=0x10) -> opcode B8, imm 0x1234, len 3, pc 0x10; next fetch at 0x13.
- CE D0 AA BB -> opext D0, imm 0xBBAA, len 4. CF 70 11 -> imm 0x0011, len 3. CE 02 -> len 2, imm 0.
- Illegal 7C at 0x20 -> fault=1, fault_pc 0x20, no insn_valid, mem_req 0. Then CE 64 at 0x30 -> ext fetched, then fault with fault_pc 0x30. Flush to 0 -> fault low next cycle and fetch resumes.
- insn_ready low 5 cycles in ISSUE -> payload unchanged, mem_req 0. Flush asserted in FETCH_IMM_HI with a 3-cycle ack delay -> request dropped, no insn_valid, fetch restarts at flush_pc.
- flush_pc=0xFFFFFF, bytes B0 @0xFFFFFF and 5A @0x000000 -> imm 0x005A, len 2; next fetch addr 0x000001.
